nearest_search_ctrl: RTL and testbench

NEAREST_SEARCH_CTRL -- requirements
Module: nearest_search_ctrl

---
 rtl/nearest_search_ctrl.sv | 121 ++++++++++++
 tb/tb_nearest_search_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/nearest_search_ctrl.sv
// Linear nearest-value search over a synchronous memory; done arrives len+2 cycles after start (cycle 1 when len==0), and start is ignored while busy.
// Defining NEAREST_SEARCH_EARLY_EXIT_EN stops the search as soon as an exact match (distance 0) is evaluated.
module nearest_search_ctrl #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] ref_val,
    input  logic [AW:0]   len,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] best_val,
    output logic [AW-1:0] best_idx,
    output logic [DW-1:0] best_dist
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [DW-1:0] r_ref;
    logic [AW:0]   r_len;
    logic [AW:0]   r_cnt;
    logic          r_pend;
    logic [AW-1:0] r_pend_idx;
    logic [DW-1:0] r_best_val;
    logic [AW-1:0] r_best_idx;
    logic [DW-1:0] r_best_dist;

    logic [DW-1:0] w_dist;
    logic          w_upd;
    logic          w_exit;
    logic          w_last_rd;
    logic          w_accept;

    // Ordered subtraction so the difference never wraps.
    assign w_dist    = (mem_data >= r_ref) ? (mem_data - r_ref) : (r_ref - mem_data);
    assign w_upd     = r_pend && ((r_pend_idx == '0) || (w_dist < r_best_dist));
    assign w_last_rd = (r_cnt == (r_len - {{AW{1'b0}}, 1'b1}));
    assign w_accept  = (r_state == IDLE) && start;

`ifdef NEAREST_SEARCH_EARLY_EXIT_EN
    assign w_exit = r_pend && (w_dist == '0);
`else
    assign w_exit = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (w_exit) begin
                    w_next_state = DONE;
                end else if (w_last_rd) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ref       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_idx  <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_best_dist <= '0;
        end else begin
            r_state <= w_next_state;
            // A read still in flight when we jump to DONE must not be evaluated.
            r_pend     <= mem_rd && (w_next_state != DONE);
            r_pend_idx <= r_cnt[AW-1:0];
            if (r_state == READ) begin
                r_cnt <= r_cnt + {{AW{1'b0}}, 1'b1};
            end
            if (w_accept) begin
                r_ref       <= ref_val;
                r_len       <= len;
                r_cnt       <= '0;
                r_best_val  <= '0;
                r_best_idx  <= '0;
                r_best_dist <= '1;
            end else if (w_upd) begin
                r_best_val  <= mem_data;
                r_best_idx  <= r_pend_idx;
                r_best_dist <= w_dist;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign mem_rd    = (r_state == READ);
    assign mem_addr  = mem_rd ? r_cnt[AW-1:0] : '0;
    assign best_val  = r_best_val;
    assign best_idx  = r_best_idx;
    assign best_dist = r_best_dist;

endmodule

// File: tb/tb_nearest_search_ctrl.sv
// Directed bench for nearest_search_ctrl with a synchronous memory model.
// Expected values depend on NEAREST_SEARCH_EARLY_EXIT_EN for the exact-match case.
module tb_nearest_search_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] ref_val;
    logic [4:0] len;
    logic       mem_rd;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       busy;
    logic       done;
    logic [7:0] best_val;
    logic [3:0] best_idx;
    logic [7:0] best_dist;

    logic [7:0] mem [16];

    int errors;
    int checks;

    nearest_search_ctrl #(.DW(8), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_val   (ref_val),
        .len       (len),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .busy      (busy),
        .done      (done),
        .best_val  (best_val),
        .best_idx  (best_idx),
        .best_dist (best_dist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Entered and left at 1ns after a rising edge; the next edge accepts start.
    task automatic run_search(input string tag, input logic [7:0] r, input logic [4:0] l,
                              input bit pulse_mid, input int exp_cyc, input int exp_reads);
        int cyc;
        int done_cyc;
        int nreads;
        bit addr_ok;
        start   = 1'b1;
        ref_val = r;
        len     = l;
        @(posedge clk); #1;
        start    = 1'b0;
        ref_val  = ~r;
        len      = 5'd1;
        cyc      = 1;
        done_cyc = -1;
        nreads   = 0;
        addr_ok  = 1'b1;
        while (cyc <= 40) begin
            if (mem_rd) begin
                if (mem_addr != nreads[3:0]) addr_ok = 1'b0;
                nreads++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = (pulse_mid && cyc == 2);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (done_cyc < 0) begin
            check_eq({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            check_eq({tag, " done_cycle"}, done_cyc, exp_cyc);
            check_eq({tag, " rd_in_done"}, {31'd0, mem_rd}, 32'd0);
            @(posedge clk); #1;
            check_eq({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        end
        check_eq({tag, " reads"}, nreads, exp_reads);
        check_eq({tag, " addr_seq"}, {31'd0, addr_ok}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [7:0] v, input logic [3:0] i,
                                input logic [7:0] d);
        check_eq({tag, " best_val"}, {24'd0, best_val}, {24'd0, v});
        check_eq({tag, " best_idx"}, {28'd0, best_idx}, {28'd0, i});
        check_eq({tag, " best_dist"}, {24'd0, best_dist}, {24'd0, d});
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " outs"},
                 {20'd0, busy, done, mem_rd, mem_addr, (best_val != 0), best_idx, (best_dist != 0)},
                 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  saw_done;
        errors   = 0;
        checks   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        ref_val  = 8'd0;
        len      = 5'd0;
        mem_data = 8'd0;
        for (int k = 0; k < 16; k++) mem[k] = 8'd0;

        #1 rst = 1'b1;
        #1;
        check_all_zero("reset");
        check_eq("reset best_dist", {24'd0, best_dist}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // First edge after release accepts this start.
        mem[0] = 8'd10; mem[1] = 8'd60; mem[2] = 8'd45; mem[3] = 8'd200;
        run_search("basic", 8'd50, 5'd4, 1'b0, 6, 4);
        check_result("basic", 8'd45, 4'd2, 8'd5);

        mem[0] = 8'd90; mem[1] = 8'd110;
        run_search("tie", 8'd100, 5'd2, 1'b0, 4, 2);
        check_result("tie", 8'd90, 4'd0, 8'd10);

        mem[0] = 8'd255; mem[1] = 8'd1;
        run_search("lo_ext", 8'd0, 5'd2, 1'b0, 4, 2);
        check_result("lo_ext", 8'd1, 4'd1, 8'd1);

        mem[0] = 8'd0; mem[1] = 8'd254;
        run_search("hi_ext", 8'd255, 5'd2, 1'b0, 4, 2);
        check_result("hi_ext", 8'd254, 4'd1, 8'd1);

        mem[0] = 8'd255; mem[1] = 8'd255;
        run_search("allones", 8'd0, 5'd2, 1'b0, 4, 2);
        check_result("allones", 8'd255, 4'd0, 8'd255);

        mem[0] = 8'd3; mem[1] = 8'd7; mem[2] = 8'd8; mem[3] = 8'd9;
`ifdef NEAREST_SEARCH_EARLY_EXIT_EN
        run_search("exact", 8'd7, 5'd4, 1'b0, 4, 3);
`else
        run_search("exact", 8'd7, 5'd4, 1'b0, 6, 4);
`endif
        check_result("exact", 8'd7, 4'd1, 8'd0);

        run_search("len0", 8'd77, 5'd0, 1'b0, 1, 0);
        check_result("len0", 8'd0, 4'd0, 8'd255);

        mem[0] = 8'd10; mem[1] = 8'd60; mem[2] = 8'd45; mem[3] = 8'd200;
        run_search("busy_start", 8'd50, 5'd4, 1'b1, 6, 4);
        check_result("busy_start", 8'd45, 4'd2, 8'd5);

        for (int k = 0; k < 16; k++) mem[k] = 8'(k * 16);
        run_search("full", 8'd245, 5'd16, 1'b0, 18, 16);
        check_result("full", 8'd240, 4'd15, 8'd5);

        // Abort a len=8 search in its third READ cycle.
        mem[0] = 8'd100; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
        mem[4] = 8'd50;  mem[5] = 8'd60; mem[6] = 8'd70; mem[7] = 8'd80;
        start   = 1'b1;
        ref_val = 8'd33;
        len     = 5'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc < 3; cyc++) begin
            @(posedge clk); #1;
        end
        check_eq("abort in_read", {31'd0, mem_rd}, 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        saw_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        check_eq("abort no_done", {31'd0, saw_done}, 32'd0);
        run_search("after_abort", 8'd33, 5'd8, 1'b0, 10, 8);
        check_result("after_abort", 8'd30, 4'd2, 8'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
